// File: rtl/dla_pool_win_if.sv
// Stream interface for dla_pool_win: input beats (LANES x DATA_WID) in, pooled results out.
// slave is the pooling unit's view; master is the producer/consumer side.
interface dla_pool_win_if #(
    parameter int DATA_WID = 16,
    parameter int LANES    = 4
);
    logic                      in_valid;
    logic                      in_ready;
    logic [LANES*DATA_WID-1:0] in_data;
    logic                      out_valid;
    logic                      out_ready;
    logic [DATA_WID-1:0]       out_data;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/dla_pool_win.sv
// Streaming window pooling (max / avg / min) over LANES x 2^beats_log2 elements, valid/ready both sides.
// Optional feature macro DLA_POOL_ROUND_EN: average rounds half toward +inf instead of flooring.
module dla_pool_win #(
    parameter int DATA_WID       = 16,
    parameter int LANES          = 4,
    parameter int MAX_BEATS_LOG2 = 3
) (
    input  logic                 clock,
    input  logic                 rst_n,
    input  logic [1:0]           cfg_mode,
    input  logic [2:0]           cfg_beats_log2,
    dla_pool_win_if.slave        bus,
    output logic                 busy
);
    localparam int LANES_LOG2 = $clog2(LANES);
    localparam int ACC_WID    = DATA_WID + LANES_LOG2 + MAX_BEATS_LOG2;
    localparam int CNT_WID    = MAX_BEATS_LOG2 + 1;
    localparam int BL_WID     = (MAX_BEATS_LOG2 > 0) ? $clog2(MAX_BEATS_LOG2 + 1) : 1;
    localparam int SH_WID     = $clog2(ACC_WID + 1);

    typedef enum logic [1:0] {
        MODE_MAX = 2'b00,
        MODE_AVG = 2'b01,
        MODE_MIN = 2'b10
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACCUM  = 2'b01,
        ST_OUTPUT = 2'b10
    } state_e;

    function automatic logic signed [ACC_WID-1:0] sext(input logic signed [DATA_WID-1:0] v);
        return {{(ACC_WID-DATA_WID){v[DATA_WID-1]}}, v};
    endfunction

    state_e                      state_q, state_d;
    mode_e                       mode_q, mode_in, win_mode;
    logic [BL_WID-1:0]           beats_log2_q, log2_in, win_log2;
    logic signed [ACC_WID-1:0]   acc_q, acc_d;
    logic [CNT_WID-1:0]          beat_cnt_q, beat_cnt_d;
    logic [DATA_WID-1:0]         out_data_q, out_data_d;

    logic signed [DATA_WID-1:0]  lane [LANES];
    logic signed [ACC_WID-1:0]   red_max, red_min, red_sum, red_sel;
    logic signed [ACC_WID-1:0]   avg_rnd;
    logic [SH_WID-1:0]           avg_shamt;
    logic                        in_fire, win_start, last_beat;

    // Combinational lane reduction of the current input beat.
    // NOTE: combinational blocks use blocking '=' and assign every output a default first,
    // so each path is fully specified and no latch is inferred.
    always_comb begin
        red_max = '0;
        red_min = '0;
        red_sum = '0;
        for (int i = 0; i < LANES; i++) begin
            lane[i] = bus.in_data[i*DATA_WID +: DATA_WID];
        end
        red_max = sext(lane[0]);
        red_min = sext(lane[0]);
        for (int i = 0; i < LANES; i++) begin
            if (sext(lane[i]) > red_max) red_max = sext(lane[i]);
            if (sext(lane[i]) < red_min) red_min = sext(lane[i]);
            red_sum = red_sum + sext(lane[i]);
        end
    end

    // Config for the window: sampled from the ports on its first beat, held afterwards.
    always_comb begin
        unique case (cfg_mode)
            2'b01:   mode_in = MODE_AVG;
            2'b10:   mode_in = MODE_MIN;
            default: mode_in = MODE_MAX;
        endcase
        if (int'(cfg_beats_log2) > MAX_BEATS_LOG2) log2_in = BL_WID'(MAX_BEATS_LOG2);
        else                                       log2_in = BL_WID'(cfg_beats_log2);

        in_fire   = bus.in_valid && bus.in_ready;
        win_start = in_fire && (state_q != ST_ACCUM);
        win_mode  = win_start ? mode_in : mode_q;
        win_log2  = win_start ? log2_in : beats_log2_q;

        unique case (win_mode)
            MODE_AVG: red_sel = red_sum;
            MODE_MIN: red_sel = red_min;
            default:  red_sel = red_max;
        endcase
    end

    // Accumulator, beat counter and the registered result.
    always_comb begin
        acc_d      = acc_q;
        beat_cnt_d = beat_cnt_q;
        if (win_start) begin
            acc_d      = red_sel;
            beat_cnt_d = CNT_WID'(1);
        end else if (in_fire) begin
            unique case (win_mode)
                MODE_AVG: acc_d = acc_q + red_sum;
                MODE_MIN: acc_d = (red_min < acc_q) ? red_min : acc_q;
                default:  acc_d = (red_max > acc_q) ? red_max : acc_q;
            endcase
            beat_cnt_d = beat_cnt_q + CNT_WID'(1);
        end
        last_beat = in_fire && (beat_cnt_d == (CNT_WID'(1) << win_log2));

        // The average divides by LANES * 2^beats_log2, a pure power of two.
        avg_shamt = SH_WID'(LANES_LOG2) + SH_WID'(win_log2);
`ifdef DLA_POOL_ROUND_EN
        if (avg_shamt == '0) avg_rnd = '0;
        else                 avg_rnd = ACC_WID'(1) << (avg_shamt - SH_WID'(1));
`else
        avg_rnd = '0;
`endif

        out_data_d = out_data_q;
        if (last_beat) begin
            if (win_mode == MODE_AVG) out_data_d = DATA_WID'((acc_d + avg_rnd) >>> avg_shamt);
            else                      out_data_d = acc_d[DATA_WID-1:0];
        end
    end

    // FSM: state register.
    // NOTE: clocked blocks use non-blocking '<=' so every register samples pre-edge values.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    // FSM: next-state logic. A beat taken during the result handshake opens the next window.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (in_fire) state_d = last_beat ? ST_OUTPUT : ST_ACCUM;
            end
            ST_ACCUM: begin
                if (last_beat) state_d = ST_OUTPUT;
            end
            ST_OUTPUT: begin
                if (bus.out_ready) begin
                    if (in_fire) state_d = last_beat ? ST_OUTPUT : ST_ACCUM;
                    else         state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM: outputs. While a result is held, input is only taken alongside its handshake.
    always_comb begin
        bus.in_ready  = (state_q == ST_OUTPUT) ? bus.out_ready : 1'b1;
        bus.out_valid = (state_q == ST_OUTPUT);
        bus.out_data  = out_data_q;
        busy          = (state_q != ST_IDLE);
    end

    // Datapath registers; an asynchronous reset discards any partial window.
    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            acc_q        <= '0;
            beat_cnt_q   <= '0;
            out_data_q   <= '0;
            mode_q       <= MODE_MAX;
            beats_log2_q <= '0;
        end else begin
            acc_q      <= acc_d;
            beat_cnt_q <= beat_cnt_d;
            out_data_q <= out_data_d;
            if (win_start) begin
                mode_q       <= mode_in;
                beats_log2_q <= log2_in;
            end
        end
    end
endmodule

// File: tb/tb_dla_pool_win.sv
// Self-checking bench for dla_pool_win: directed vector table, hand-written handshake/reset
// sequences, and randomized windows checked against a division-based reference model.
module tb_dla_pool_win;
    localparam int DW = 16;
    localparam int LN = 4;
`ifdef DLA_POOL_ROUND_EN
    localparam bit ROUND_EN = 1'b1;
`else
    localparam bit ROUND_EN = 1'b0;
`endif

    logic       clock;
    logic       rst_n;
    logic [1:0] cfg_mode;
    logic [2:0] cfg_beats_log2;
    logic       busy;

    dla_pool_win_if #(.DATA_WID(DW), .LANES(LN)) bus ();

    dla_pool_win #(.DATA_WID(DW), .LANES(LN), .MAX_BEATS_LOG2(3)) dut (
        .clock          (clock),
        .rst_n          (rst_n),
        .cfg_mode       (cfg_mode),
        .cfg_beats_log2 (cfg_beats_log2),
        .bus            (bus),
        .busy           (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string          name;
        logic [1:0]     mode;
        logic [2:0]     log2;
        logic [7:0][63:0] beats;
        int             exp_v;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input int act, input int exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp_v);
        end
    endtask

    function automatic logic [63:0] pk(input int a, input int b, input int c, input int d);
        return {d[15:0], c[15:0], b[15:0], a[15:0]};
    endfunction

    function automatic int nb(input logic [2:0] l);
        return 1 << ((l > 3'd3) ? 3 : int'(l));
    endfunction

    function automatic int out_val();
        return int'($signed(bus.out_data));
    endfunction

    // Reference: pool a flat list of elements by plain arithmetic.
    function automatic int ref_pool(input int mode, input int q[$]);
        int     n  = q.size();
        longint s  = 0;
        int     mx = q[0];
        int     mn = q[0];
        longint r;
        foreach (q[i]) begin
            s += q[i];
            if (q[i] > mx) mx = q[i];
            if (q[i] < mn) mn = q[i];
        end
        if (mode == 1) begin
            if (ROUND_EN && n > 1) s = s + n / 2;
            r = s / n;
            if ((s % n) != 0 && s < 0) r = r - 1;
            return int'(r);
        end
        if (mode == 2) return mn;
        return mx;
    endfunction

    function automatic int rand_elem();
        logic [15:0] r;
        r = 16'($urandom);
        case ($urandom % 5)
            0:       return -32768;
            1:       return 32767;
            default: return int'($signed(r));
        endcase
    endfunction

    // Called just after a rising edge; returns just after the edge that accepted the beat.
    task automatic push_beat(input logic [63:0] d);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        #1;
        while (!bus.in_ready && n < 100) begin
            @(posedge clock); #2;
            n++;
        end
        if (n >= 100) check("in_ready_timeout", 0, 1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
    endtask

    // Raises out_ready, waits (bounded) for out_valid, records the value and completes the handshake.
    task automatic get_out(output int v, output int waited);
        int n = 0;
        bus.out_ready = 1'b1;
        #1;
        while (!bus.out_valid && n < 50) begin
            @(posedge clock); #2;
            n++;
        end
        if (n >= 50) check("out_valid_timeout", 0, 1);
        v      = out_val();
        waited = n;
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int v, lat;
        int       q[$];
        logic [63:0] d;
        int       mode, lg, el;

        for (int k = 0; k < 7; k++) vecs[k].beats = '0;
        vecs[0].name = "max_b1";   vecs[0].mode = 2'd0; vecs[0].log2 = 3'd0; vecs[0].exp_v = 7;
        vecs[0].beats[0] = pk(3, -5, 7, 2);
        vecs[1].name = "avg_b2";   vecs[1].mode = 2'd1; vecs[1].log2 = 3'd1; vecs[1].exp_v = ROUND_EN ? 5 : 4;
        vecs[1].beats[0] = pk(1, 2, 3, 4);
        vecs[1].beats[1] = pk(5, 6, 7, 8);
        vecs[2].name = "avg_neg";  vecs[2].mode = 2'd1; vecs[2].log2 = 3'd0; vecs[2].exp_v = ROUND_EN ? -2 : -3;
        vecs[2].beats[0] = pk(-1, -2, -3, -4);
        vecs[3].name = "min_b4";   vecs[3].mode = 2'd2; vecs[3].log2 = 3'd2; vecs[3].exp_v = -32768;
        vecs[3].beats[0] = pk(100, -7, 5, 0);
        vecs[3].beats[1] = pk(1, 2, -32768, 3);
        vecs[3].beats[2] = pk(-100, 4, 4, 4);
        vecs[3].beats[3] = pk(9, 9, 9, 9);
        vecs[4].name = "avg_full"; vecs[4].mode = 2'd1; vecs[4].log2 = 3'd3; vecs[4].exp_v = 32767;
        for (int j = 0; j < 8; j++) vecs[4].beats[j] = pk(32767, 32767, 32767, 32767);
        vecs[5].name = "rsv_mode"; vecs[5].mode = 2'd3; vecs[5].log2 = 3'd1; vecs[5].exp_v = -1;
        vecs[5].beats[0] = pk(-9, -8, -7, -6);
        vecs[5].beats[1] = pk(-20, -1, -30, -40);
        vecs[6].name = "clamp";    vecs[6].mode = 2'd2; vecs[6].log2 = 3'd7; vecs[6].exp_v = -5;
        for (int j = 0; j < 8; j++) vecs[6].beats[j] = pk(j * 3 - 5, 100, 7, 8);

        rst_n          = 1'b0;
        cfg_mode       = '0;
        cfg_beats_log2 = '0;
        bus.in_valid   = 1'b0;
        bus.in_data    = '0;
        bus.out_ready  = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        check("rst_out_valid", int'(bus.out_valid), 0);
        check("rst_busy",      int'(busy), 0);
        check("rst_in_ready",  int'(bus.in_ready), 1);
        check("rst_out_data",  out_val(), 0);
        rst_n = 1'b1;
        @(posedge clock); #1;

        // Directed vector table.
        for (int k = 0; k < 7; k++) begin
            cfg_mode       = vecs[k].mode;
            cfg_beats_log2 = vecs[k].log2;
            for (int j = 0; j < nb(vecs[k].log2); j++) push_beat(vecs[k].beats[j]);
            #1;
            check({vecs[k].name, "_busy_held"}, int'(busy), 1);
            get_out(v, lat);
            check({vecs[k].name, "_data"}, v, vecs[k].exp_v);
            check({vecs[k].name, "_latency"}, lat, 0);
            #1;
            check({vecs[k].name, "_busy_after"}, int'(busy), 0);
            check({vecs[k].name, "_valid_after"}, int'(bus.out_valid), 0);
        end

        // Back-pressure for 5 cycles, then release with a new beat in the same cycle.
        @(posedge clock); #1;
        cfg_mode = 2'd0; cfg_beats_log2 = 3'd0;
        push_beat(pk(1, 2, 3, 4));
        bus.in_valid = 1'b1;
        bus.in_data  = pk(10, 40, 30, 20);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_out_valid", int'(bus.out_valid), 1);
            check("bp_in_ready",  int'(bus.in_ready), 0);
            check("bp_out_data",  out_val(), 4);
            @(posedge clock); #1;
        end
        bus.out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", int'(bus.in_ready), 1);
        @(posedge clock); #1;
        bus.in_valid = 1'b0;
        check("nobubble_out_valid", int'(bus.out_valid), 1);
        check("nobubble_out_data",  out_val(), 40);
        @(posedge clock); #1;
        bus.out_ready = 1'b0;
        check("nobubble_idle_valid", int'(bus.out_valid), 0);
        check("nobubble_idle_busy",  int'(busy), 0);

        // Asynchronous reset in the middle of a 4-beat average window.
        cfg_mode = 2'd1; cfg_beats_log2 = 3'd2;
        push_beat(pk(100, 200, 300, 400));
        push_beat(pk(100, 200, 300, 400));
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", int'(bus.out_valid), 0);
        check("midrst_busy",      int'(busy), 0);
        @(posedge clock); #1;
        rst_n = 1'b1;
        @(posedge clock); #1;
        for (int j = 0; j < 4; j++) push_beat(pk(1, 1, 1, 1));
        get_out(v, lat);
        check("postrst_avg", v, 1);

        // Randomized windows: cfg scrambled mid-window, input gaps, delayed out_ready.
        for (int w = 0; w < 40; w++) begin
            mode = int'($urandom % 4);
            lg   = int'($urandom % 8);
            q.delete();
            cfg_mode       = 2'(mode);
            cfg_beats_log2 = 3'(lg);
            for (int b = 0; b < nb(3'(lg)); b++) begin
                d = '0;
                for (int l = 0; l < LN; l++) begin
                    el = rand_elem();
                    q.push_back(el);
                    d[l*DW +: DW] = el[15:0];
                end
                push_beat(d);
                cfg_mode       = 2'($urandom);
                cfg_beats_log2 = 3'($urandom);
                repeat ($urandom % 3) begin
                    @(posedge clock); #1;
                end
            end
            #1;
            check("rand_valid_held", int'(bus.out_valid), 1);
            get_out(v, lat);
            check($sformatf("rand_w%0d_m%0d_l%0d", w, mode, lg), v, ref_pool(mode, q));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
